// File: rtl/regfile_wport_arbiter.sv
// regfile_wport_arbiter: zero-fills r1..r31 after reset, then round-robin shares the register file write port between A and B.
module regfile_wport_arbiter #(
    parameter int AW        = 5,
    parameter int DW        = 32,
    parameter int INIT_ZERO = 1
) (
    input  logic          i_clk,
    input  logic          i_clr,
    input  logic          i_req_a,
    input  logic [AW-1:0] i_wr_a,
    input  logic [DW-1:0] i_d_a,
    output logic          o_gnt_a,
    input  logic          i_req_b,
    input  logic [AW-1:0] i_wr_b,
    input  logic [DW-1:0] i_d_b,
    output logic          o_gnt_b,
    output logic          o_we,
    output logic [AW-1:0] o_wr,
    output logic [DW-1:0] o_d,
    output logic          o_busy
);
    typedef enum logic {S_INIT, S_ARB} state_t;
    state_t        r_state;
    logic [AW-1:0] r_cnt;
    logic          r_rr;
    logic          r_we;
    logic [AW-1:0] r_wr;
    logic [DW-1:0] r_d;
    logic          r_busy;
    logic          w_arb;
    // r_rr=0 favours A; grants are forced low while reset is held
    assign w_arb   = (r_state == S_ARB) && !i_clr;
    assign o_gnt_a = w_arb && i_req_a && (!i_req_b || !r_rr);
    assign o_gnt_b = w_arb && i_req_b && (!i_req_a || r_rr);
    assign o_we    = r_we;
    assign o_wr    = r_wr;
    assign o_d     = r_d;
    assign o_busy  = r_busy;
    always_ff @(posedge i_clk or posedge i_clr) begin
        if (i_clr) begin
            r_state <= (INIT_ZERO != 0) ? S_INIT : S_ARB;
            r_busy  <= (INIT_ZERO != 0);
            r_cnt   <= AW'(1);
            r_rr    <= 1'b0;
            r_we    <= 1'b0;
            r_wr    <= '0;
            r_d     <= '0;
        end else if (r_state == S_INIT) begin
            r_we  <= 1'b1;
            r_wr  <= r_cnt;
            r_d   <= '0;
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == {AW{1'b1}}) begin
                r_state <= S_ARB;
                r_busy  <= 1'b0;
            end
        end else if (o_gnt_a) begin
            r_we <= |i_wr_a;
            r_wr <= i_wr_a;
            r_d  <= i_d_a;
            r_rr <= 1'b1;
        end else if (o_gnt_b) begin
            r_we <= |i_wr_b;
            r_wr <= i_wr_b;
            r_d  <= i_d_b;
            r_rr <= 1'b0;
        end else begin
            r_we <= 1'b0;
        end
    end
endmodule

// File: tb/tb_regfile_wport_arbiter.sv
// tb_regfile_wport_arbiter: directed checks of INIT zero-fill, round-robin grants, r0 suppression and mid-INIT reset.
module tb_regfile_wport_arbiter;
    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic        req_a = 1'b0, req_b = 1'b0;
    logic [4:0]  wr_a = '0, wr_b = '0;
    logic [31:0] d_a = '0, d_b = '0;
    logic        o_gnt_a, o_gnt_b, o_we, o_busy;
    logic [4:0]  o_wr;
    logic [31:0] o_d;
    logic [31:0] mem [32];
    logic        r0_written = 1'b0;
    int          n_chk = 0;
    int          n_fail = 0;

    regfile_wport_arbiter #(.AW(5), .DW(32), .INIT_ZERO(1)) dut (
        .i_clk(clk), .i_clr(clr),
        .i_req_a(req_a), .i_wr_a(wr_a), .i_d_a(d_a), .o_gnt_a(o_gnt_a),
        .i_req_b(req_b), .i_wr_b(wr_b), .i_d_b(d_b), .o_gnt_b(o_gnt_b),
        .o_we(o_we), .o_wr(o_wr), .o_d(o_d), .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    // register file model fed by the DUT write port
    always @(posedge clk) begin
        if (o_we) begin
            mem[o_wr] <= o_d;
            if (o_wr == 5'd0) r0_written <= 1'b1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic init_seq(input int n);
        for (int i = 1; i <= n; i++) begin
            @(posedge clk); #1;
            chk("init_we", 32'(o_we), 1);
            chk("init_wr", 32'(o_wr), i);
            chk("init_d", o_d, 0);
            chk("init_busy", 32'(o_busy), 32'(i < 31));
            if (i < 31) begin
                chk("init_gnt_a", 32'(o_gnt_a), 0);
                chk("init_gnt_b", 32'(o_gnt_b), 0);
            end
        end
    endtask

    initial begin
        logic [31:0] nz;
        #12;
        chk("rst_we", 32'(o_we), 0);
        chk("rst_wr", 32'(o_wr), 0);
        chk("rst_d", o_d, 0);
        chk("rst_busy", 32'(o_busy), 1);
        chk("rst_gnt", 32'({o_gnt_a, o_gnt_b}), 0);
        clr = 1'b0;
        init_seq(16);
        #1 clr = 1'b1;
        req_a = 1'b1; wr_a = 5'd5; d_a = 32'hDEADBEEF;
        #1;
        chk("midrst_we", 32'(o_we), 0);
        chk("midrst_wr", 32'(o_wr), 0);
        chk("midrst_d", o_d, 0);
        chk("midrst_busy", 32'(o_busy), 1);
        chk("midrst_gnt_a", 32'(o_gnt_a), 0);
        clr = 1'b0;
        init_seq(31);
        chk("arb_busy", 32'(o_busy), 0);
        chk("arb_gnt_a", 32'(o_gnt_a), 1);
        chk("arb_gnt_b", 32'(o_gnt_b), 0);
        @(posedge clk); #1;
        chk("t3_we", 32'(o_we), 1);
        chk("t3_wr", 32'(o_wr), 5);
        chk("t3_d", o_d, 32'hDEADBEEF);
        req_a = 1'b0;
        @(posedge clk); #1;
        chk("idle_we", 32'(o_we), 0);
        chk("idle_wr", 32'(o_wr), 5);
        chk("idle_d", o_d, 32'hDEADBEEF);
        chk("t3_mem5", mem[5], 32'hDEADBEEF);
        nz = '0;
        for (int r = 1; r < 32; r++) if (r != 5 && mem[r] !== 32'h0) nz[r] = 1'b1;
        chk("zero_fill", nz, 0);
        req_b = 1'b1; wr_b = 5'd7; d_b = 32'h77;
        #1;
        chk("single_b_gnt", 32'({o_gnt_a, o_gnt_b}), 1);
        @(posedge clk); #1;
        chk("single_b_wr", 32'(o_wr), 7);
        chk("single_b_d", o_d, 32'h77);
        req_b = 1'b0;
        req_a = 1'b1; wr_a = 5'd3; d_a = 32'hA3;
        req_b = 1'b1; wr_b = 5'd4; d_b = 32'hB4;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("rr_gnt_a", 32'(o_gnt_a), 32'(k % 2 == 0));
            chk("rr_gnt_b", 32'(o_gnt_b), 32'(k % 2 == 1));
            @(posedge clk); #1;
            chk("rr_we", 32'(o_we), 1);
            chk("rr_wr", 32'(o_wr), (k % 2 == 0) ? 3 : 4);
            chk("rr_d", o_d, (k % 2 == 0) ? 32'hA3 : 32'hB4);
        end
        req_a = 1'b0; req_b = 1'b0;
        req_b = 1'b1; wr_b = 5'd0; d_b = 32'hFFFFFFFF;
        #1;
        chk("r0_gnt_b", 32'(o_gnt_b), 1);
        @(posedge clk); #1;
        chk("r0_we", 32'(o_we), 0);
        chk("r0_wr", 32'(o_wr), 0);
        chk("r0_d", o_d, 32'hFFFFFFFF);
        req_b = 1'b0;
        @(posedge clk); #1;
        chk("r0_not_written", 32'(r0_written), 0);
        req_a = 1'b1; wr_a = 5'd9; d_a = 32'h99;
        req_b = 1'b1; wr_b = 5'd10; d_b = 32'h1010;
        #1;
        chk("after_r0_gnt_a", 32'(o_gnt_a), 1);
        chk("after_r0_gnt_b", 32'(o_gnt_b), 0);
        @(posedge clk); #1;
        chk("after_r0_wr", 32'(o_wr), 9);
        req_a = 1'b0; req_b = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
